rf_load_sched: RTL and testbench

//  Sequencer for the AddrToRF register-file loader. Walks a feature map in
//  row-major order at a programmable stride and pulses the loader's start.

---
 rtl/rf_load_sched.sv | 140 ++++++++++++++
 tb/tb_rf_load_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_load_sched.sv
// rf_load_sched: walks a feature map row-major at a programmable stride, pulsing the AddrToRF loader and handing each loaded window to the PE array.
// Optional feature macro PERF_CNT_EN adds o_stall_cnt, a saturating count of HANDOFF cycles with i_pe_ready low.
module rf_load_sched #(
  parameter int HW    = 7,
  parameter int S_W   = 3,
  parameter int CNT_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [HW-1:0]  i_map_h,
  input  logic [HW-1:0]  i_map_w,
  input  logic [S_W-1:0] i_stride,
  output logic           o_rf_start,
  input  logic           i_rf_finish,
  output logic [HW-1:0]  o_h,
  output logic [HW-1:0]  o_w,
  output logic           o_pe_valid,
  input  logic           i_pe_ready,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HANDOFF,
    ST_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [HW-1:0]  map_h_q;
  logic [HW-1:0]  map_w_q;
  logic [S_W-1:0] stride_q;
  logic [HW-1:0]  h_q;
  logic [HW-1:0]  w_q;
  logic           err_q;

  logic           cfg_bad;
  logic           start_acc;
  logic           accept;
  logic [HW:0]    stride_x;
  logic [HW:0]    nw;
  logic [HW:0]    nh;
  logic           row_end;
  logic           pass_end;

  assign cfg_bad   = (i_stride == '0) || (i_map_h == '0) || (i_map_w == '0);
  assign start_acc = (state == ST_IDLE) && i_start;
  assign accept    = (state == ST_HANDOFF) && i_pe_ready;

  // One extra bit so a step past a 2^HW-1 edge compares correctly instead of wrapping.
  assign stride_x  = {{(HW + 1 - S_W){1'b0}}, stride_q};
  assign nw        = {1'b0, w_q} + stride_x;
  assign nh        = {1'b0, h_q} + stride_x;
  assign row_end   = (nw >= {1'b0, map_w_q});
  assign pass_end  = row_end && (nh >= {1'b0, map_h_q});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (i_start && !cfg_bad) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT:    if (i_rf_finish) state_nxt = ST_HANDOFF;
      ST_HANDOFF: if (i_pe_ready) state_nxt = pass_end ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Config and position registers; the last position is kept through DONE and IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      map_h_q  <= '0;
      map_w_q  <= '0;
      stride_q <= '0;
      h_q      <= '0;
      w_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= start_acc && cfg_bad;
      if (start_acc) begin
        map_h_q  <= i_map_h;
        map_w_q  <= i_map_w;
        stride_q <= i_stride;
        if (!cfg_bad) begin
          h_q <= '0;
          w_q <= '0;
        end
      end else if (accept) begin
        if (!row_end) begin
          w_q <= nw[HW-1:0];
        end else if (!pass_end) begin
          w_q <= '0;
          h_q <= nh[HW-1:0];
        end
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if (start_acc && !cfg_bad) begin
      stall_cnt_q <= '0;
    end else if ((state == ST_HANDOFF) && !i_pe_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

  assign o_rf_start = (state == ST_ISSUE);
  assign o_pe_valid = (state == ST_HANDOFF);
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_DONE);
  assign o_err      = err_q;
  assign o_h        = h_q;
  assign o_w        = w_q;

endmodule

// File: tb/tb_rf_load_sched.sv
// Bench for rf_load_sched: transaction-level model (precomputed window list) checked every cycle, plus directed literal checks.
module tb_rf_load_sched;
  localparam int HW      = 7;
  localparam int S_W     = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_start = 1'b0;
  logic [HW-1:0]  i_map_h = '0;
  logic [HW-1:0]  i_map_w = '0;
  logic [S_W-1:0] i_stride = '0;
  logic           o_rf_start;
  logic           i_rf_finish = 1'b0;
  logic [HW-1:0]  o_h;
  logic [HW-1:0]  o_w;
  logic           o_pe_valid;
  logic           i_pe_ready = 1'b1;
  logic           o_busy;
  logic           o_done;
  logic           o_err;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] o_stall_cnt;
`endif

  rf_load_sched #(.HW(HW), .S_W(S_W), .CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_map_h     (i_map_h),
    .i_map_w     (i_map_w),
    .i_stride    (i_stride),
    .o_rf_start  (o_rf_start),
    .i_rf_finish (i_rf_finish),
    .o_h         (o_h),
    .o_w         (o_w),
    .o_pe_valid  (o_pe_valid),
    .i_pe_ready  (i_pe_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
`ifdef PERF_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: the whole pass is expanded into a window list up front.
  int  qh[$];
  int  qw[$];
  bit  model_ok = 1'b0;
  bit  m_busy = 1'b0;
  bit  m_wait = 1'b0;
  bit  m_prev_start;
  bit  m_prev_done;
  bit  e_rf_start = 1'b0;
  bit  e_pe_valid = 1'b0;
  bit  e_done = 1'b0;
  bit  e_err = 1'b0;
  int  e_h = 0;
  int  e_w = 0;
  int  e_cnt = 0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      model_ok = 1'b1;
      m_busy = 0; m_wait = 0;
      e_rf_start = 0; e_pe_valid = 0; e_done = 0; e_err = 0;
      e_h = 0; e_w = 0; e_cnt = 0;
      qh.delete(); qw.delete();
    end else begin
      m_prev_start = e_rf_start;
      m_prev_done  = e_done;
      e_rf_start = 0; e_done = 0; e_err = 0;
      if (!m_busy) begin
        if (i_start) begin
          if (i_stride == 0 || i_map_h == 0 || i_map_w == 0) begin
            e_err = 1;
          end else begin
            qh.delete(); qw.delete();
            for (int r = 0; r < int'(i_map_h); r += int'(i_stride))
              for (int c = 0; c < int'(i_map_w); c += int'(i_stride)) begin
                qh.push_back(r);
                qw.push_back(c);
              end
            m_busy = 1; e_rf_start = 1; e_cnt = 0;
            e_h = qh[0]; e_w = qw[0];
          end
        end
      end else if (m_prev_done) begin
        m_busy = 0;
      end else if (m_prev_start) begin
        m_wait = 1;
      end else if (m_wait) begin
        if (i_rf_finish) begin
          m_wait = 0;
          e_pe_valid = 1;
        end
      end else if (e_pe_valid) begin
        if (i_pe_ready) begin
          e_pe_valid = 0;
          void'(qh.pop_front());
          void'(qw.pop_front());
          if (qh.size() == 0) begin
            e_done = 1;
          end else begin
            e_rf_start = 1;
            e_h = qh[0]; e_w = qw[0];
          end
        end else if (e_cnt < CNT_MAX) begin
          e_cnt++;
        end
      end
    end
  end

  int n_starts = 0;
  int n_done = 0;
  int n_err = 0;
  int ph [0:399];
  int pw [0:399];

  always @(negedge i_clk) begin
    if (model_ok) begin
      chk("rf_start", o_rf_start, e_rf_start);
      chk("pe_valid", o_pe_valid, e_pe_valid);
      chk("done", o_done, e_done);
      chk("err", o_err, e_err);
      chk("busy", o_busy, m_busy);
      chk("h", o_h, e_h);
      chk("w", o_w, e_w);
`ifdef PERF_CNT_EN
      chk("stall_cnt", o_stall_cnt, e_cnt);
`endif
      if (o_rf_start) begin
        if (n_starts < 400) begin
          ph[n_starts] = o_h;
          pw[n_starts] = o_w;
        end
        n_starts++;
      end
      if (o_done) n_done++;
      if (o_err) n_err++;
    end
  end

  // Loader/PE stand-in: finish two cycles after each start, optional backpressure.
  bit fin_en = 1'b1;
  bit extra_fin = 1'b0;
  int stall_left = 0;

  initial begin
    int dly;
    dly = 0;
    forever begin
      @(posedge i_clk);
      #2;
      i_rf_finish = extra_fin;
      if (i_rst) begin
        dly = 0;
      end else if (o_rf_start && fin_en) begin
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) i_rf_finish = 1'b1;
      end
      if (o_pe_valid && stall_left > 0) begin
        i_pe_ready = 1'b0;
        stall_left--;
      end else begin
        i_pe_ready = 1'b1;
      end
    end
  end

  task automatic do_start(input int mh, input int mw, input int st);
    @(posedge i_clk); #1;
    i_map_h  = HW'(mh);
    i_map_w  = HW'(mw);
    i_stride = S_W'(st);
    i_start  = 1'b1;
    @(posedge i_clk); #1;
    i_start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        seen = 1;
        break;
      end
    end
    chk(name, seen, 1);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mon();
    n_starts = 0; n_done = 0; n_err = 0;
  endtask

  int exp2_h [0:5] = '{0, 0, 2, 2, 4, 4};
  int exp2_w [0:5] = '{0, 2, 0, 2, 0, 2};

  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("reset_busy", o_busy, 0);
    chk("reset_rf_start", o_rf_start, 0);
    chk("reset_h", o_h, 0);
    chk("reset_w", o_w, 0);

    // 3x3 stride 1
    clear_mon();
    do_start(3, 3, 1);
    wait_done("t1_done_seen", 200);
    chk("t1_starts", n_starts, 9);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_first_h", ph[0], 0);
    chk("t1_second_w", pw[1], 1);
    chk("t1_last_h", ph[8], 2);
    chk("t1_last_w", pw[8], 2);
    chk("t1_idle_h", o_h, 2);

    // 5x4 stride 2
    clear_mon();
    do_start(5, 4, 2);
    wait_done("t2_done_seen", 200);
    chk("t2_starts", n_starts, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_h", ph[i], exp2_h[i]);
      chk("t2_w", pw[i], exp2_w[i]);
    end

    // Illegal configurations
    clear_mon();
    do_start(3, 3, 0);
    chk("t3_err_stride0", o_err, 1);
    chk("t3_busy_stride0", o_busy, 0);
    @(posedge i_clk); #1;
    chk("t3_err_pulse_end", o_err, 0);
    do_start(3, 0, 1);
    chk("t3_err_mapw0", o_err, 1);
    repeat (5) @(posedge i_clk);
    #1;
    chk("t3_no_starts", n_starts, 0);
    chk("t3_err_cnt", n_err, 2);

    // Backpressure on the first window
    clear_mon();
    stall_left = 4;
    do_start(2, 2, 1);
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge i_clk); #1;
        if (o_pe_valid) begin
          got = 1;
          break;
        end
      end
      chk("t4_valid_seen", got, 1);
    end
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("t4_valid_held", o_pe_valid, 1);
      chk("t4_h_held", o_h, 0);
      chk("t4_w_held", o_w, 0);
      chk("t4_one_start", n_starts, 1);
    end
    wait_done("t4_done_seen", 200);
    chk("t4_starts", n_starts, 4);
`ifdef PERF_CNT_EN
    chk("t4_stall_cnt", o_stall_cnt, 4);
`endif

    // Reset while waiting on the loader
    clear_mon();
    fin_en = 1'b0;
    do_start(3, 3, 1);
    @(posedge i_clk); #1;
    chk("t5_busy_wait", o_busy, 1);
    chk("t5_valid_wait", o_pe_valid, 0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_rf_start", o_rf_start, 0);
    chk("t5_rst_valid", o_pe_valid, 0);
    chk("t5_rst_done", o_done, 0);
    chk("t5_rst_err", o_err, 0);
    chk("t5_rst_h", o_h, 0);
    chk("t5_rst_w", o_w, 0);
    extra_fin = 1'b1;
    @(posedge i_clk); #1;
    extra_fin = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("t5_late_fin_starts", n_starts, 1);
    chk("t5_late_fin_busy", o_busy, 0);
    fin_en = 1'b1;
    clear_mon();
    do_start(2, 3, 1);
    wait_done("t5_done_seen", 200);
    chk("t5_restart_starts", n_starts, 6);
    chk("t5_restart_h", ph[0], 0);
    chk("t5_restart_w", pw[0], 0);

    // Full-size map with mid-pass disturbances
    clear_mon();
    do_start(127, 127, 7);
    repeat (20) @(posedge i_clk);
    #1;
    i_map_h = 7'd5;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done("t6_done_seen", 5000);
    chk("t6_starts", n_starts, 361);
    chk("t6_last_h", ph[360], 126);
    chk("t6_last_w", pw[360], 126);
    chk("t6_done_cnt", n_done, 1);
    chk("t6_idle_w", o_w, 126);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
